// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the mux2_arbiter block.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // Round-robin pick: a lone requester wins; on a tie, the side not served last wins.
    function automatic logic rr_pick(input logic a_req, input logic b_req, input logic last_served);
        logic pick;
        pick = SEL_B;
        if (a_req && (!b_req || (last_served == SEL_B))) begin
            pick = SEL_A;
        end
        return pick;
    endfunction

    // Serve state that corresponds to a select value.
    function automatic state_t serve_of(input logic side);
        return (side == SEL_A) ? SERVE_A : SERVE_B;
    endfunction

endpackage

// File: rtl/mux2.sv
// Generic 2-to-1 multiplexer: sel = 0 passes d0, sel = 1 passes d1.
module mux2 #(
    parameter int unsigned W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_arb_outreg.sv
// Single-entry valid/ready output register for mux2_arbiter.
// out_free reports that a word may be loaded this cycle.
module mux2_arb_outreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         y_ready,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    output logic         out_free
);

    // Slot is free when empty, or when the held word leaves on this edge.
    assign out_free = !y_valid || y_ready;

    // Capture on load; otherwise drain when the consumer accepts; data holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else if (load) begin
            y_valid <= 1'b1;
            y_data  <= data_in;
        end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin sequencer for a shared 2-to-1 mux feeding a single-entry
// valid/ready output stage. Optional burst grants under MUX2_ARB_BURST_EN
// (adds a_last/b_last; a grant holds until a word marked last is captured).
module mux2_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         a_req,
    input  logic [W-1:0] a_data,
`ifdef MUX2_ARB_BURST_EN
    input  logic         a_last,
    input  logic         b_last,
`endif
    output logic         a_ack,
    input  logic         b_req,
    input  logic [W-1:0] b_data,
    output logic         b_ack,
    output logic         sel,
    output logic         y_valid,
    output logic [W-1:0] y_data,
    input  logic         y_ready
);

    state_t         state;
    logic           last_served;
    logic           out_free;
    logic           load;
    logic           a_last_eff;
    logic           b_last_eff;
    logic [W-1:0]   mux_y;

`ifdef MUX2_ARB_BURST_EN
    assign a_last_eff = a_last;
    assign b_last_eff = b_last;
`else
    // Without bursts every grant covers exactly one word.
    assign a_last_eff = 1'b1;
    assign b_last_eff = 1'b1;
`endif

    // Acks fire only in the matching serve state with a free output slot, never in reset.
    assign a_ack = !reset && (state == SERVE_A) && out_free;
    assign b_ack = !reset && (state == SERVE_B) && out_free;
    assign load  = a_ack || b_ack;

    // Shared datapath selection, steered by the registered select.
    mux2 #(.W(W)) u_mux (
        .sel (sel),
        .d0  (a_data),
        .d1  (b_data),
        .y   (mux_y)
    );

    // Output stage; sel always matches the serve state, so mux_y is the served word.
    mux2_arb_outreg #(.W(W)) u_outreg (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data_in  (mux_y),
        .y_ready  (y_ready),
        .y_valid  (y_valid),
        .y_data   (y_data),
        .out_free (out_free)
    );

    // Arbitration FSM with registered select and round-robin history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            sel         <= SEL_A;
            last_served <= SEL_B;
        end else begin
            unique case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state <= serve_of(rr_pick(a_req, b_req, last_served));
                        sel   <= rr_pick(a_req, b_req, last_served);
                    end
                end
                SERVE_A: begin
                    if (a_ack && a_last_eff) begin
                        state       <= IDLE;
                        last_served <= SEL_A;
                    end
                end
                SERVE_B: begin
                    if (b_ack && b_last_eff) begin
                        state       <= IDLE;
                        last_served <= SEL_B;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: reset, single grant, contention,
// backpressure, mid-operation reset and (with MUX2_ARB_BURST_EN) bursts.
module tb_mux2_arbiter;
    import mux2_arb_pkg::*;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         a_req;
    logic [W-1:0] a_data;
    logic         a_ack;
    logic         b_req;
    logic [W-1:0] b_data;
    logic         b_ack;
    logic         sel;
    logic         y_valid;
    logic [W-1:0] y_data;
    logic         y_ready;
`ifdef MUX2_ARB_BURST_EN
    logic         a_last;
    logic         b_last;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mux2_arbiter #(.W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .a_req   (a_req),
        .a_data  (a_data),
`ifdef MUX2_ARB_BURST_EN
        .a_last  (a_last),
        .b_last  (b_last),
`endif
        .a_ack   (a_ack),
        .b_req   (b_req),
        .b_data  (b_data),
        .b_ack   (b_ack),
        .sel     (sel),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Handshake invariants: never both acks, none in reset, no ack without a request.
    always @(negedge clk) begin
        check("mon_dual_ack", 32'(a_ack && b_ack), 32'(0));
        check("mon_ack_in_reset", 32'(reset && (a_ack || b_ack)), 32'(0));
        check("mon_a_req_dropped", 32'(a_ack && !a_req), 32'(0));
        check("mon_b_req_dropped", 32'(b_ack && !b_req), 32'(0));
    end

    initial begin
        reset   = 1'b1;
        a_req   = 1'b1;
        a_data  = 8'hA5;
        b_req   = 1'b0;
        b_data  = 8'h00;
        y_ready = 1'b1;
`ifdef MUX2_ARB_BURST_EN
        a_last  = 1'b1;
        b_last  = 1'b1;
`endif

        // Reset held two cycles with a pending A request.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_y_valid", 32'(y_valid), 32'(0));
            check("rst_y_data", 32'(y_data), 32'(0));
            check("rst_sel", 32'(sel), 32'(0));
            check("rst_a_ack", 32'(a_ack), 32'(0));
        end
        reset = 1'b0;
        #1;
        check("idle_a_ack", 32'(a_ack), 32'(0));

        // Single A word.
        tick();
        check("single_a_ack", 32'(a_ack), 32'(1));
        check("single_sel", 32'(sel), 32'(0));
        check("single_y_valid_early", 32'(y_valid), 32'(0));
        tick();
        check("single_ack_off", 32'(a_ack), 32'(0));
        check("single_y_valid", 32'(y_valid), 32'(1));
        check("single_y_data", 32'(y_data), 32'(8'hA5));
        a_req = 1'b0;
        tick();
        check("single_drain", 32'(y_valid), 32'(0));

        // Contention: continuous requests alternate A, B, A, B.
        reset  = 1'b1;
        a_req  = 1'b1;
        b_req  = 1'b1;
        a_data = 8'h11;
        b_data = 8'h22;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic exp_b;
            exp_b = (i % 2) == 1;
            tick();
            check("cont_a_ack", 32'(a_ack), 32'(!exp_b));
            check("cont_b_ack", 32'(b_ack), 32'(exp_b));
            check("cont_sel", 32'(sel), 32'(exp_b));
            tick();
            check("cont_y_valid", 32'(y_valid), 32'(1));
            check("cont_y_data", 32'(y_data), exp_b ? 32'(8'h22) : 32'(8'h11));
        end
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        check("cont_drain", 32'(y_valid), 32'(0));

        // Backpressure: 33 held, B stalls until the consumer is ready.
        a_req  = 1'b1;
        a_data = 8'h33;
        tick();
        check("bp_a_ack", 32'(a_ack), 32'(1));
        y_ready = 1'b0;
        tick();
        check("bp_y_valid", 32'(y_valid), 32'(1));
        check("bp_y_data", 32'(y_data), 32'(8'h33));
        a_req  = 1'b0;
        b_req  = 1'b1;
        b_data = 8'h44;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_b_ack_stall", 32'(b_ack), 32'(0));
            check("bp_sel", 32'(sel), 32'(1));
            check("bp_state", 32'(dut.state), 32'(SERVE_B));
            check("bp_y_data_hold", 32'(y_data), 32'(8'h33));
            check("bp_y_valid_hold", 32'(y_valid), 32'(1));
        end
        y_ready = 1'b1;
        #1;
        check("bp_b_ack_release", 32'(b_ack), 32'(1));
        tick();
        check("bp_y_valid_new", 32'(y_valid), 32'(1));
        check("bp_y_data_new", 32'(y_data), 32'(8'h44));
        check("bp_b_ack_off", 32'(b_ack), 32'(0));
        b_req = 1'b0;
        tick();
        check("bp_drain", 32'(y_valid), 32'(0));

        // Mid-operation reset while stalled in SERVE_A with a word held.
        y_ready = 1'b0;
        a_req   = 1'b1;
        a_data  = 8'h66;
        tick();
        check("mr_a_ack", 32'(a_ack), 32'(1));
        tick();
        check("mr_y_data", 32'(y_data), 32'(8'h66));
        a_data = 8'h77;
        tick();
        check("mr_state_serve", 32'(dut.state), 32'(SERVE_A));
        check("mr_a_ack_stall", 32'(a_ack), 32'(0));
        check("mr_y_valid_held", 32'(y_valid), 32'(1));
        reset = 1'b1;
        #1;
        check("mr_a_ack_in_reset", 32'(a_ack), 32'(0));
        tick();
        check("mr_y_valid_cleared", 32'(y_valid), 32'(0));
        check("mr_y_data_cleared", 32'(y_data), 32'(0));
        check("mr_state_idle", 32'(dut.state), 32'(IDLE));
        check("mr_sel", 32'(sel), 32'(0));
        reset = 1'b0;
        #1;
        check("mr_a_ack_idle", 32'(a_ack), 32'(0));
        tick();
        check("mr_rearb_ack", 32'(a_ack), 32'(1));
        y_ready = 1'b1;
        tick();
        check("mr_rearb_valid", 32'(y_valid), 32'(1));
        check("mr_rearb_data", 32'(y_data), 32'(8'h77));
        a_req = 1'b0;
        tick();
        check("mr_drain", 32'(y_valid), 32'(0));

`ifdef MUX2_ARB_BURST_EN
        // Burst: A sends 01, 02, 03 (last) back-to-back while B waits.
        reset  = 1'b1;
        a_req  = 1'b1;
        a_last = 1'b0;
        a_data = 8'h01;
        b_req  = 1'b1;
        b_last = 1'b1;
        b_data = 8'hBB;
        tick();
        reset = 1'b0;
        tick();
        check("burst_first_ack", 32'(a_ack), 32'(1));
        check("burst_first_sel", 32'(sel), 32'(0));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("burst_y_valid", 32'(y_valid), 32'(1));
            check("burst_y_data", 32'(y_data), 32'(k));
            check("burst_sel", 32'(sel), 32'(0));
            if (k < 3) begin
                a_data = 8'(k + 1);
                a_last = (k + 1) == 3;
                check("burst_state_locked", 32'(dut.state), 32'(SERVE_A));
                check("burst_a_ack", 32'(a_ack), 32'(1));
                check("burst_b_ack", 32'(b_ack), 32'(0));
            end
        end
        a_req = 1'b0;
        check("burst_end_state", 32'(dut.state), 32'(IDLE));
        tick();
        check("burst_b_ack", 32'(b_ack), 32'(1));
        check("burst_b_sel", 32'(sel), 32'(1));
        tick();
        check("burst_b_data", 32'(y_data), 32'(8'hBB));
        b_req = 1'b0;
        tick();
        check("burst_drain", 32'(y_valid), 32'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
